// File: rtl/issue_select_if.sv
// Handshake bundle between the compacting queue, the scoreboard and the issue selector.
// The slave modport is the selector's view; the master modport is the surrounding logic's view.
interface issue_select_if #(
  parameter int  Size       = 4,
  parameter int  IssueWidth = 2,
  parameter type T          = logic [31:0]
);
  localparam int SW = $clog2(Size + 1);
  localparam int CW = $clog2(IssueWidth + 1);

  logic [SW-1:0]         i_size;
  T     [Size-1:0]       i_entry;
  logic [Size-1:0]       i_ready;
  logic                  i_flush;
  logic [Size-1:0]       o_pop;
  logic                  i_accept;
  logic [IssueWidth-1:0] o_valid;
  T     [IssueWidth-1:0] o_data;
  logic [CW-1:0]         o_count;

  modport slave (
    input  i_size, i_entry, i_ready, i_flush, i_accept,
    output o_pop, o_valid, o_data, o_count
  );

  modport master (
    output i_size, i_entry, i_ready, i_flush, i_accept,
    input  o_pop, o_valid, o_data, o_count
  );
endinterface

// File: rtl/issue_select.sv
// Picks up to IssueWidth ready queue entries oldest-first, pops them from the queue and
// holds them in a registered issue group released through a valid/accept handshake.
module issue_select #(
  parameter int  Size       = 4,
  parameter int  IssueWidth = 2,
  parameter type T          = logic [31:0]
) (
  input  logic              i_clk,
  input  logic              i_rst,
  issue_select_if.slave     bus
);
  localparam int CW = $clog2(IssueWidth + 1);

  logic [Size-1:0]       w_sel;
  int                    w_rank [Size];
  logic [IssueWidth-1:0] w_slot_vld;
  T     [IssueWidth-1:0] w_slot_data;
  logic [CW-1:0]         w_npick;
  logic                  w_can_load;

  logic [IssueWidth-1:0] r_valid_p1;
  T     [IssueWidth-1:0] r_data_p1;
  logic [CW-1:0]         r_count_p1;

  // Stage p0: combinational oldest-first scan of the visible queue entries
  always_comb begin
    int n;
    n = 0;
    w_sel = '0;
    for (int k = 0; k < Size; k++) begin
      w_rank[k] = 0;
      if ((k < int'(bus.i_size)) && bus.i_ready[k] && (n < IssueWidth)) begin
        w_sel[k]  = 1'b1;
        w_rank[k] = n;
        n = n + 1;
      end
    end
    w_npick = CW'(n);
  end

  always_comb begin
    w_slot_vld  = '0;
    w_slot_data = '0;
    for (int j = 0; j < IssueWidth; j++) begin
      for (int k = 0; k < Size; k++) begin
        if (w_sel[k] && (w_rank[k] == j)) begin
          w_slot_vld[j]  = 1'b1;
          w_slot_data[j] = bus.i_entry[k];
        end
      end
    end
  end

  assign w_can_load = (r_valid_p1 == '0) || bus.i_accept;

  // A pop is only issued when the pick is guaranteed to be captured on this edge.
  assign bus.o_pop = w_sel & {Size{w_can_load & ~bus.i_flush & ~i_rst}};

  // Stage p1: registered issue group
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_flush) begin
      r_valid_p1 <= '0;
      r_data_p1  <= '0;
      r_count_p1 <= '0;
    end else if (w_can_load) begin
      r_valid_p1 <= w_slot_vld;
      r_data_p1  <= w_slot_data;
      r_count_p1 <= w_npick;
    end
  end

  assign bus.o_valid = r_valid_p1;
  assign bus.o_data  = r_data_p1;
  assign bus.o_count = r_count_p1;
endmodule

// File: tb/tb_issue_select.sv
// Directed scenario bench for issue_select with Size=4, IssueWidth=2, 32-bit entries.
module tb_issue_select;
  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  issue_select_if #(.Size(4), .IssueWidth(2), .T(logic [31:0])) bus ();

  issue_select #(.Size(4), .IssueWidth(2), .T(logic [31:0])) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entries(input logic [31:0] e0, e1, e2, e3);
    bus.i_entry[0] = e0;
    bus.i_entry[1] = e1;
    bus.i_entry[2] = e2;
    bus.i_entry[3] = e3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_size = 3'd3;
    bus.i_ready = 4'b1111;
    set_entries(32'd1, 32'd2, 32'd3, 32'd4);
    #1;
    n_chk++;
    if (bus.o_pop !== 4'b0000) begin
      n_err++; $display("FAIL rst_pop got=%b exp=0000", bus.o_pop);
    end
    step(); step();
    n_chk++;
    if (bus.o_valid !== 2'b00 || bus.o_count !== 2'd0 || bus.o_data !== 64'd0) begin
      n_err++; $display("FAIL rst_out got valid=%b count=%0d data=%h exp 00/0/0", bus.o_valid, bus.o_count, bus.o_data);
    end
    rst = 1'b0;
    bus.i_size = 3'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++;
      if (bus.o_pop !== 4'b0000 || bus.o_valid !== 2'b00 || bus.o_count !== 2'd0) begin
        n_err++; $display("FAIL idle_c%0d got pop=%b valid=%b count=%0d exp 0000/00/0", c, bus.o_pop, bus.o_valid, bus.o_count);
      end
      step();
    end
  endtask

  task automatic test_basic();
    bus.i_size = 3'd3;
    set_entries(32'd5, 32'd6, 32'd7, 32'd0);
    bus.i_ready = 4'b1111;
    bus.i_accept = 1'b0;
    #1;
    n_chk++;
    if (bus.o_pop !== 4'b0011) begin
      n_err++; $display("FAIL basic_pop got=%b exp=0011", bus.o_pop);
    end
    step();
    n_chk++;
    if (bus.o_valid !== 2'b11 || bus.o_data[0] !== 32'd5 || bus.o_data[1] !== 32'd6 || bus.o_count !== 2'd2) begin
      n_err++; $display("FAIL basic_grp got valid=%b d0=%0d d1=%0d count=%0d exp 11/5/6/2", bus.o_valid, bus.o_data[0], bus.o_data[1], bus.o_count);
    end
    n_chk++;
    if (bus.o_pop !== 4'b0000) begin
      n_err++; $display("FAIL basic_held_pop got=%b exp=0000", bus.o_pop);
    end
  endtask

  task automatic test_sparse();
    bus.i_accept = 1'b1;
    bus.i_size = 3'd4;
    set_entries(32'd1, 32'd2, 32'd3, 32'd4);
    bus.i_ready = 4'b1010;
    #1;
    n_chk++;
    if (bus.o_pop !== 4'b1010) begin
      n_err++; $display("FAIL sparse_pop got=%b exp=1010", bus.o_pop);
    end
    step();
    bus.i_accept = 1'b0;
    n_chk++;
    if (bus.o_valid !== 2'b11 || bus.o_data[0] !== 32'd2 || bus.o_data[1] !== 32'd4 || bus.o_count !== 2'd2) begin
      n_err++; $display("FAIL sparse_grp got valid=%b d0=%0d d1=%0d count=%0d exp 11/2/4/2", bus.o_valid, bus.o_data[0], bus.o_data[1], bus.o_count);
    end
  endtask

  task automatic test_hold();
    bus.i_size = 3'd4;
    set_entries(32'd7, 32'd8, 32'd9, 32'd10);
    bus.i_ready = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_chk++;
      if (bus.o_pop !== 4'b0000 || bus.o_data[0] !== 32'd2 || bus.o_data[1] !== 32'd4 || bus.o_valid !== 2'b11) begin
        n_err++; $display("FAIL hold_c%0d got pop=%b d0=%0d d1=%0d valid=%b exp 0000/2/4/11", c, bus.o_pop, bus.o_data[0], bus.o_data[1], bus.o_valid);
      end
      step();
    end
    bus.i_accept = 1'b1;
    bus.i_size = 3'd1;
    set_entries(32'd9, 32'd0, 32'd0, 32'd0);
    bus.i_ready = 4'b0001;
    #1;
    n_chk++;
    if (bus.o_pop !== 4'b0001) begin
      n_err++; $display("FAIL hold_release_pop got=%b exp=0001", bus.o_pop);
    end
    step();
    n_chk++;
    if (bus.o_valid !== 2'b01 || bus.o_data[0] !== 32'd9 || bus.o_data[1] !== 32'd0 || bus.o_count !== 2'd1) begin
      n_err++; $display("FAIL hold_release_grp got valid=%b d0=%0d d1=%0d count=%0d exp 01/9/0/1", bus.o_valid, bus.o_data[0], bus.o_data[1], bus.o_count);
    end
  endtask

  task automatic test_back_to_back();
    bus.i_accept = 1'b1;
    bus.i_size = 3'd2;
    set_entries(32'd10, 32'd11, 32'd12, 32'd13);
    bus.i_ready = 4'b1111;
    #1;
    n_chk++;
    if (bus.o_pop !== 4'b0011) begin
      n_err++; $display("FAIL size_limit_pop got=%b exp=0011", bus.o_pop);
    end
    step();
    n_chk++;
    if (bus.o_valid !== 2'b11 || bus.o_data[0] !== 32'd10 || bus.o_data[1] !== 32'd11) begin
      n_err++; $display("FAIL b2b_grp got valid=%b d0=%0d d1=%0d exp 11/10/11", bus.o_valid, bus.o_data[0], bus.o_data[1]);
    end
    bus.i_ready = 4'b1100;
    #1;
    n_chk++;
    if (bus.o_pop !== 4'b0000) begin
      n_err++; $display("FAIL beyond_size_pop got=%b exp=0000", bus.o_pop);
    end
    step();
    n_chk++;
    if (bus.o_valid !== 2'b00 || bus.o_count !== 2'd0) begin
      n_err++; $display("FAIL drain_empty got valid=%b count=%0d exp 00/0", bus.o_valid, bus.o_count);
    end
  endtask

  task automatic test_flush_reset();
    bus.i_accept = 1'b0;
    bus.i_size = 3'd4;
    set_entries(32'd1, 32'd2, 32'd3, 32'd4);
    bus.i_ready = 4'b1010;
    step();
    bus.i_flush = 1'b1;
    bus.i_accept = 1'b1;
    bus.i_ready = 4'b1111;
    #1;
    n_chk++;
    if (bus.o_pop !== 4'b0000) begin
      n_err++; $display("FAIL flush_pop got=%b exp=0000", bus.o_pop);
    end
    step();
    bus.i_flush = 1'b0;
    bus.i_accept = 1'b0;
    n_chk++;
    if (bus.o_valid !== 2'b00 || bus.o_count !== 2'd0 || bus.o_data !== 64'd0) begin
      n_err++; $display("FAIL flush_grp got valid=%b count=%0d data=%h exp 00/0/0", bus.o_valid, bus.o_count, bus.o_data);
    end
    step();
    n_chk++;
    if (bus.o_valid !== 2'b11 || bus.o_data[0] !== 32'd1 || bus.o_data[1] !== 32'd2) begin
      n_err++; $display("FAIL reload_grp got valid=%b d0=%0d d1=%0d exp 11/1/2", bus.o_valid, bus.o_data[0], bus.o_data[1]);
    end
    bus.i_accept = 1'b1;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.o_pop !== 4'b0000) begin
      n_err++; $display("FAIL rst_mid_pop got=%b exp=0000", bus.o_pop);
    end
    step();
    rst = 1'b0;
    bus.i_accept = 1'b0;
    n_chk++;
    if (bus.o_valid !== 2'b00 || bus.o_count !== 2'd0 || bus.o_data !== 64'd0) begin
      n_err++; $display("FAIL rst_mid_grp got valid=%b count=%0d data=%h exp 00/0/0", bus.o_valid, bus.o_count, bus.o_data);
    end
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst = 1'b1;
    bus.i_size = '0;
    bus.i_entry = '0;
    bus.i_ready = '0;
    bus.i_flush = 1'b0;
    bus.i_accept = 1'b0;
    step();
    test_reset();
    test_basic();
    test_sparse();
    test_hold();
    test_back_to_back();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
